// File: rtl/uart_fifo_ctrl.sv
// CPU-facing UART front end: TX and RX byte FIFOs, a paced TX drain FSM and
// a one-shot RX acknowledge FSM, exposed as a data register and a status word.
module uart_fifo_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [15:0] io_addr,
  input  logic [31:0] io_dout,
  output logic [31:0] io_din,
  output logic        uart_wr,
  output logic [7:0]  uart_w,
  input  logic        uart_busy,
  output logic        uart_rd,
  input  logic        uart_valid,
  input  logic [7:0]  uart_data
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_HOLD} tx_state_t;
  typedef enum logic       {RX_IDLE, RX_ACK} rx_state_t;

  logic [7:0]       tx_mem [DEPTH];
  logic [7:0]       rx_mem [DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [4:0]       tx_count, rx_count;
  logic             tx_overflow;
  tx_state_t        tx_state;
  rx_state_t        rx_state;

  logic tx_push_req, tx_push, tx_drop, tx_pop, ovf_clr, rx_push, rx_pop;
  logic unused_bits;

  assign tx_push_req = io_wr & io_addr[12];
  assign tx_push     = tx_push_req & (tx_count != DEPTH_C);
  assign tx_drop     = tx_push_req & (tx_count == DEPTH_C);
  assign tx_pop      = (tx_state == TX_IDLE) & (tx_count != 5'd0) & ~uart_busy;
  assign ovf_clr     = io_wr & io_addr[13] & io_dout[3];
  assign rx_push     = (rx_state == RX_IDLE) & uart_valid & (rx_count != DEPTH_C);
  assign rx_pop      = io_rd & io_addr[12] & (rx_count != 5'd0);

  assign unused_bits = ^{io_dout[31:8], io_addr[15:14], io_addr[11:0]};

  function automatic logic [31:0] status_word(
    input logic [4:0] tx_cnt,
    input logic [4:0] rx_cnt,
    input logic       tx_idle,
    input logic       ovf
  );
    logic [31:0] w;
    w        = '0;
    w[0]     = (tx_cnt < DEPTH_C);
    w[1]     = (rx_cnt != 5'd0);
    w[2]     = (tx_cnt == 5'd0) & tx_idle;
    w[3]     = ovf;
    w[12:8]  = tx_cnt;
    w[20:16] = rx_cnt;
    return w;
  endfunction

  always_comb begin
    io_din = '0;
    if (io_addr[12])
      io_din[7:0] = (rx_count != 5'd0) ? rx_mem[rx_rd_ptr] : 8'h00;
    if (io_addr[13])
      io_din = io_din | status_word(tx_count, rx_count, tx_state == TX_IDLE, tx_overflow);
  end

  // FIFO storage carries no reset; pointers and counts alone define contents.
  always_ff @(posedge clk) begin
    if (resetq && tx_push)
      tx_mem[tx_wr_ptr] <= io_dout[7:0];
    if (resetq && rx_push)
      rx_mem[rx_wr_ptr] <= uart_data;
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      tx_count    <= '0;
      rx_count    <= '0;
      tx_overflow <= 1'b0;
      tx_state    <= TX_IDLE;
      rx_state    <= RX_IDLE;
      uart_wr     <= 1'b0;
      uart_rd     <= 1'b0;
      uart_w      <= 8'h00;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      tx_count <= tx_count + 5'(tx_push) - 5'(tx_pop);
      rx_count <= rx_count + 5'(rx_push) - 5'(rx_pop);

      // A dropped byte outranks a same-cycle clear so the loss stays visible.
      if (tx_drop)
        tx_overflow <= 1'b1;
      else if (ovf_clr)
        tx_overflow <= 1'b0;

      case (tx_state)
        TX_IDLE: begin
          uart_wr <= 1'b0;
          if (tx_pop) begin
            uart_w   <= tx_mem[tx_rd_ptr];
            uart_wr  <= 1'b1;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          uart_wr  <= 1'b0;
          tx_state <= TX_HOLD;
        end
        TX_HOLD: begin
          uart_wr  <= 1'b0;
          tx_state <= TX_IDLE;
        end
        default: begin
          uart_wr  <= 1'b0;
          tx_state <= TX_IDLE;
        end
      endcase

      // RX_ACK masks uart_valid while the core is still deasserting it.
      case (rx_state)
        RX_IDLE: begin
          uart_rd <= rx_push;
          if (rx_push)
            rx_state <= RX_ACK;
        end
        RX_ACK: begin
          uart_rd  <= 1'b0;
          rx_state <= RX_IDLE;
        end
        default: begin
          uart_rd  <= 1'b0;
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, entries per FIFO; power of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 resetq  input  1  reset, synchronous, active-low.
REQ-004 io_wr  input  1  CPU I/O write strobe, one cycle per access.
REQ-005 io_rd  input  1  CPU I/O read strobe, one cycle per access.
REQ-006 io_addr  input  16  one-hot I/O select; bit 12 = UART data, bit 13 = UART status.
REQ-007 io_dout  input  32  CPU write data.
REQ-008 io_din  output  32  read data, combinational; 0 when neither io_addr[12] nor io_addr[13] is set.
REQ-009 uart_wr  output  1  registered one-cycle transmit strobe to the UART core.
REQ-010 uart_w  output  8  registered transmit byte; valid while uart_wr=1.
REQ-011 uart_busy  input  1  UART transmitter busy.
REQ-012 uart_rd  output  1  registered one-cycle receive acknowledge to the UART core.
REQ-013 uart_valid  input  1  UART receive byte available.
REQ-014 uart_data  input  8  UART received byte.

Function
REQ-015 TX FIFO: io_wr & io_addr[12] pushes io_dout[7:0] when tx_count<DEPTH; on a full FIFO the byte is dropped and sticky tx_overflow is set; this holds even when the drain FSM pops in the same cycle.
REQ-016 TX drain FSM states: TX_IDLE, TX_SEND, TX_HOLD.
REQ-017 TX_IDLE -> TX_SEND when tx_count>0 and uart_busy=0; otherwise stay in TX_IDLE.
REQ-018 Entering TX_SEND registers uart_w=FIFO head and uart_wr=1 for exactly one cycle; the head is popped on that edge; next state is TX_HOLD.
REQ-019 TX_HOLD lasts one cycle, ignoring uart_busy, then returns to TX_IDLE; consecutive strobes are at least 3 cycles apart.
REQ-020 RX FSM states: RX_IDLE, RX_ACK.
REQ-021 RX_IDLE with uart_valid=1 and rx_count<DEPTH: uart_data is written to the RX FIFO, uart_rd=1 is registered for one cycle, and the FSM enters RX_ACK.
REQ-022 RX_ACK lasts one cycle, ignoring uart_valid, then returns to RX_IDLE.
REQ-023 RX full with uart_valid=1: no capture and no uart_rd; the byte stays pending in the UART core and no data is lost.
REQ-024 io_din[7:0] with io_addr[12] set = RX head, or 0 when the RX FIFO is empty; bits [31:8] = 0.
REQ-025 io_rd & io_addr[12] pops the RX head when rx_count>0; on an empty FIFO there is no pop and no state change.
REQ-026 A simultaneous RX capture and CPU pop both take effect and rx_count is unchanged; a simultaneous TX push (not full) and drain pop both take effect.
REQ-027 Status word (io_addr[13]):
- bit0 = tx_count<DEPTH
- bit1 = rx_count>0
- bit2 = tx_count==0 and TX FSM in TX_IDLE
- bit3 = tx_overflow
- bits[12:8] = tx_count
- bits[20:16] = rx_count
- all other bits 0
REQ-028 io_wr & io_addr[13] with io_dout[3]=1 clears tx_overflow; a push dropped in the same cycle wins, leaving tx_overflow set.
REQ-029 Both select bits set: io_din = bitwise OR of the two words; both write and read side effects apply.
REQ-030 Pointers wrap modulo DEPTH; counts range 0..DEPTH inclusive (5-bit field).

Reset
REQ-031 resetq=0 at a clock edge sets:
- pointers and counts to 0
- tx_overflow to 0
- both FSMs to IDLE
- uart_wr=0, uart_rd=0, uart_w=8'h00
REQ-032 Reset mid-transfer abandons the current operation, discards FIFO contents, and suppresses any strobe on the following cycle.
REQ-033 While resetq=0, io strobes and UART inputs are ignored.

Verification
REQ-034 Write 0x41 with uart_busy=0 -> uart_wr pulses once, 2 cycles after the write, with uart_w=0x41; status bit2=1 two cycles later.
REQ-035 Hold uart_busy=1 and write 9 bytes 0x00..0x08 (DEPTH=8) -> tx_count=8, bit3=1; release busy -> exactly 0x00..0x07 are sent in order, 3 cycles apart; write bit3 to clear -> bit3=0.
REQ-036 Drive uart_valid=1 with uart_data=0x5A -> uart_rd pulses 1 cycle later; the status read shows rx_count=1 and bit1=1; the data read returns 0x5A, then rx_count=0.
REQ-037 Fill the RX FIFO to 8 with valid held high -> uart_rd stays low; one CPU pop -> the 9th byte is captured within 2 cycles and ordering is preserved.
REQ-038 Assert resetq=0 on the TX_SEND cycle with 3 bytes queued -> the next cycle has uart_wr=0, the status word reads 0x00000005, and no further strobes follow.
REQ-039 Read with io_addr=0x0001 -> io_din=0 and no FIFO change; read the empty RX FIFO -> 0 and rx_count stays 0.
